// File: rtl/conv_out_collector_pkg.sv
// Shared constants and geometry helpers for the convolution output collector.
// Latency: n/a (declarations only). Backpressure: n/a.
// Exports the PE-chain result width and the output-map geometry functions.
package conv_out_collector_pkg;
`include "global.v"

   localparam int DSP_WIDTH = `OUTPUT_DSP_WIDTH;

   // Number of stride-1 window positions along one edge.
   function automatic int full_size(input int k, input int fm, input int p);
      return fm + 2 * p - k + 1;
   endfunction

   // Number of kept positions along one edge after striding.
   function automatic int out_size(input int full, input int s);
      return (full - 1) / s + 1;
   endfunction
endpackage

// File: rtl/conv_out_fifo.sv
// First-word-fall-through FIFO buffering requantised samples.
// Latency: a write is visible at rdata on the edge that stores it; reads are combinational.
// Backpressure: caller must not write when full unless it pops in the same cycle.
// Ports: clk/rst (async high), wr/wdata write side, rd pop, rdata head, full/empty status.
module conv_out_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_rd = rd && !empty;
   // A pop in the same cycle frees a slot, so a write into a full FIFO is kept.
   assign do_wr = wr && (!full || do_rd);
   assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/global.v
// Global build defaults shared by the convolution datapath.
// Each value may be overridden from the command line before this file is read.
// OUTPUT_DSP_WIDTH is the width of the signed result leaving the PE chain.
`ifndef GLOBAL_V_DEFS
`define GLOBAL_V_DEFS
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef FM_SIZE
`define FM_SIZE 5
`endif
`ifndef PADDING
`define PADDING 1
`endif
`ifndef STRIDE
`define STRIDE 2
`endif
`ifndef OUTPUT_DSP_WIDTH
`define OUTPUT_DSP_WIDTH 48
`endif
`endif

// File: rtl/conv_out_collector.sv
// Collects PE-chain results, keeps strided positions, requantises and buffers them.
// Latency: 2 edges from accepted i_en to the FIFO, o_valid follows on that edge.
// Backpressure: i_ready stalls the FIFO; a write to a full FIFO is dropped and flags o_overflow.
// Ports: i_clk, i_rst (async high), i_en/i_data input samples, o_valid/i_ready/o_data output,
//        o_frame_done end-of-frame pulse, o_overflow sticky drop flag.
// Build option: CONV_OUT_RELU_EN clamps negative inputs to zero before rounding.
module conv_out_collector
   import conv_out_collector_pkg::*;
#(
   parameter int KERNEL_SIZE = `KERNEL_SIZE,
   parameter int FM_SIZE     = `FM_SIZE,
   parameter int PADDING     = `PADDING,
   parameter int STRIDE      = `STRIDE,
   parameter int SHIFT       = 8,
   parameter int OUT_WIDTH   = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic signed [DSP_WIDTH-1:0] i_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic signed [OUT_WIDTH-1:0] o_data,
   output logic                        o_frame_done,
   output logic                        o_overflow
);
   localparam int FULL_SIZE = full_size(KERNEL_SIZE, FM_SIZE, PADDING);
   localparam int OUT_SIZE  = out_size(FULL_SIZE, STRIDE);
   localparam int W         = DSP_WIDTH;
   localparam int CW        = (FULL_SIZE > 1) ? $clog2(FULL_SIZE) : 1;

   localparam logic signed [W:0] HALF = (W+1)'(1) << (SHIFT - 1);
   localparam logic signed [W:0] MAXV = {{(W + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [W:0] MINV = {{(W + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

   logic [CW-1:0]              row;
   logic [CW-1:0]              col;
   logic                       last_col;
   logic                       last_row;
   logic                       keep;
   logic signed [W-1:0]        din;
   logic signed [W:0]          rnd;
   logic signed [W:0]          shf;
   logic signed [OUT_WIDTH-1:0] sat;
   logic                       q_vld;
   logic [OUT_WIDTH-1:0]       q_dat;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [OUT_WIDTH-1:0]       fifo_head;
   logic                       pop;

   assign last_col = (col == CW'(FULL_SIZE - 1));
   assign last_row = (row == CW'(FULL_SIZE - 1));
   assign keep     = (row % STRIDE == 0) && (row / STRIDE < OUT_SIZE) &&
                     (col % STRIDE == 0) && (col / STRIDE < OUT_SIZE);

   // Requantise: optional ReLU, round-half-up with one guard bit, shift, saturate.
   always_comb begin
`ifdef CONV_OUT_RELU_EN
      din = i_data[W-1] ? '0 : i_data;
`else
      din = i_data;
`endif
      rnd = $signed({din[W-1], din}) + HALF;
      shf = rnd >>> SHIFT;
      if (shf > MAXV)      sat = MAXV[OUT_WIDTH-1:0];
      else if (shf < MINV) sat = MINV[OUT_WIDTH-1:0];
      else                 sat = shf[OUT_WIDTH-1:0];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         row          <= '0;
         col          <= '0;
         q_vld        <= 1'b0;
         q_dat        <= '0;
         o_frame_done <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         o_frame_done <= i_en && last_col && last_row;
         q_vld        <= i_en && keep;
         if (i_en && keep) q_dat <= sat;
         if (i_en) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         // Sample from the pipeline stage lost because the FIFO had no room.
         if (q_vld && fifo_full && !pop) o_overflow <= 1'b1;
      end
   end

   assign o_valid = !fifo_empty;
   assign pop     = o_valid && i_ready;
   assign o_data  = $signed(fifo_head);

   conv_out_fifo #(
      .WIDTH (OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .wr    (q_vld),
      .wdata (q_dat),
      .rd    (pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_conv_out_collector.sv
// Scoreboard bench for conv_out_collector (K=3, FM=5, P=1, S=2 geometry).
// Expected samples are queued as stimulus is driven and popped on each output handshake.
// Covers reset state, raster keep pattern, rounding, saturation, ReLU option, overflow, mid-frame reset.
module tb_conv_out_collector;
   import conv_out_collector_pkg::*;

   localparam int SHIFT  = 8;
   localparam int OW     = 16;
   localparam int DEPTH  = 8;
   localparam int FULL   = 5;
   localparam int NPOS   = FULL * FULL;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic                        en = 1'b0;
   logic signed [DSP_WIDTH-1:0] data = '0;
   logic                        ready = 1'b1;
   logic                        valid;
   logic signed [OW-1:0]        dout;
   logic                        frame_done;
   logic                        overflow;

   int     n_checks = 0;
   int     n_errors = 0;
   int     fd_cnt = 0;
   bit     exp_ovf = 0;
   longint sb[$];

   conv_out_collector #(
      .KERNEL_SIZE (3),
      .FM_SIZE     (5),
      .PADDING     (1),
      .STRIDE      (2),
      .SHIFT       (SHIFT),
      .OUT_WIDTH   (OW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_data       (data),
      .o_valid      (valid),
      .i_ready      (ready),
      .o_data       (dout),
      .o_frame_done (frame_done),
      .o_overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint requant(input longint d);
      longint v;
      longint hi;
      longint lo;
      v = d;
`ifdef CONV_OUT_RELU_EN
      if (v < 0) v = 0;
`endif
      v  = (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
      hi = (64'sd1 <<< (OW - 1)) - 1;
      lo = -(64'sd1 <<< (OW - 1));
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return v;
   endfunction

   function automatic longint pattern(input int mode, input int p);
      if (mode == 0) return longint'(p) * 256;
      case (p)
         0:  return 384;
         2:  return -384;
         4:  return 64'sd1 <<< 40;
         10: return -(64'sd1 <<< 40);
         12: return -1000;
         14: return 255;
         20: return 127;
         22: return -129;
         24: return -(64'sd1 <<< 47);
         default: return longint'(p) * 1000 - 7000;
      endcase
   endfunction

   // Output side: every handshake seen before the next edge must match the queue head.
   always @(negedge clk) begin
      if (!rst && frame_done) fd_cnt++;
      if (!rst && valid && ready) begin
         if (sb.size() == 0) check("spurious_out", 1, 0);
         else check("out_data", longint'(dout), sb.pop_front());
      end
   end

   // Drive n positions of a frame; stall=1 models a FIFO that never drains.
   task automatic drive(input int n, input int mode, input bit gaps, input bit stall);
      for (int p = 0; p < n; p++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            en   = 1'b0;
            data = DSP_WIDTH'($urandom());
            @(posedge clk); #1;
         end
         en   = 1'b1;
         data = DSP_WIDTH'(pattern(mode, p));
         if (((p / FULL) % 2 == 0) && ((p % FULL) % 2 == 0)) begin
            if (stall && sb.size() >= DEPTH) exp_ovf = 1;
            else sb.push_back(requant(pattern(mode, p)));
         end
         @(posedge clk); #1;
         if (p == NPOS - 1) check("frame_done_pulse", longint'(frame_done), 1);
      end
      en = 1'b0;
      data = '0;
      @(posedge clk); #1;
      check("frame_done_low", longint'(frame_done), 0);
   endtask

   task automatic drain(input string tag);
      int budget;
      budget = 200;
      while ((sb.size() != 0 || valid) && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check(tag, longint'(sb.size()), 0);
      check({tag, "_empty"}, longint'(valid), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", longint'(valid), 0);
      check("rst_data", longint'(dout), 0);
      check("rst_frame_done", longint'(frame_done), 0);
      check("rst_overflow", longint'(overflow), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Ramp frame, continuous enables.
      drive(NPOS, 0, 0, 0);
      drain("ramp_drain");
      check("ramp_fd_count", longint'(fd_cnt), 1);

      // Rounding, saturation and ReLU corners with idle gaps and garbage data.
      drive(NPOS, 1, 1, 0);
      drain("corner_drain");
      check("corner_fd_count", longint'(fd_cnt), 2);
      check("corner_no_ovf", longint'(overflow), 0);

      // Full-frame stall: eight held, ninth dropped.
      ready = 1'b0;
      exp_ovf = 0;
      drive(NPOS, 0, 0, 1);
      repeat (4) @(posedge clk);
      #1;
      check("bp_overflow", longint'(overflow), longint'(exp_ovf));
      check("bp_held", longint'(sb.size()), DEPTH);
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", longint'(valid), 1);
         check("bp_hold_data", longint'(dout), sb[0]);
         @(posedge clk); #1;
      end
      ready = 1'b1;
      drain("bp_drain");
      check("bp_ovf_sticky", longint'(overflow), 1);

      // Reset part-way through a frame.
      drive(12, 0, 0, 0);
      rst = 1'b1;
      sb.delete();
      #1;
      check("mid_rst_valid", longint'(valid), 0);
      check("mid_rst_overflow", longint'(overflow), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      fd_cnt = 0;
      drive(NPOS, 0, 0, 0);
      drain("post_rst_drain");
      check("post_rst_fd_count", longint'(fd_cnt), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
